// File: rtl/jpeg_rle_if.sv
// rtl/jpeg_rle_if.sv - coefficient-in / symbol-out handshake bundle for jpeg_rle_encoder
interface jpeg_rle_if #(
  parameter int DATA_WIDTH = 10
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_dc;
  logic [3:0]            out_run;
  logic [3:0]            out_size;
  logic [DATA_WIDTH:0]   out_amp;
  logic                  out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_dc, out_run, out_size, out_amp, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_dc, out_run, out_size, out_amp, out_last
  );
endinterface

// File: rtl/jpeg_rle_encoder.sv
// rtl/jpeg_rle_encoder.sv - zigzag coefficient run-length / DC-difference symbol encoder
// Optional block/symbol counters are compiled in with JPEG_RLE_STATS_EN.
module jpeg_rle_encoder #(
  parameter int DATA_WIDTH = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         dc_clear,
`ifdef JPEG_RLE_STATS_EN
  output logic [15:0]  stat_blocks,
  output logic [15:0]  stat_symbols,
`endif
  jpeg_rle_if.slave    bus
);
  localparam int AW = DATA_WIDTH + 1;

  typedef enum logic { S_RUN, S_FLUSH } state_t;

  state_t                       r_state, w_state_next;
  logic [5:0]                   r_index;
  logic [3:0]                   r_run;
  logic [1:0]                   r_zrl_pend;
  logic signed [DATA_WIDTH-1:0] r_pred;

  logic                         r_out_valid, r_out_dc, r_out_last;
  logic [3:0]                   r_out_run, r_out_size;
  logic [AW-1:0]                r_out_amp;

  logic [3:0]                   r_hold_run, r_hold_size;
  logic [AW-1:0]                r_hold_amp;
  logic                         r_hold_last;

  logic                         w_in_ready, w_accept, w_out_fire;
  logic                         w_is_dc, w_is_last, w_nz;
  logic signed [DATA_WIDTH-1:0] w_in_s, w_pred_eff;
  logic signed [AW-1:0]         w_val, w_diff;
  logic [AW-1:0]                w_mag, w_amp_raw, w_mask, w_amp;
  logic [3:0]                   w_size;

  assign w_in_ready = (r_state == S_RUN) && (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_out_fire = r_out_valid && bus.out_ready;
  assign w_is_dc    = (r_index == 6'd0);
  assign w_is_last  = (r_index == 6'd63);
  assign w_nz       = (bus.in_data != '0);

  // A DC accepted together with dc_clear must already see a zero predictor.
  assign w_in_s     = $signed(bus.in_data);
  assign w_pred_eff = dc_clear ? '0 : r_pred;
  assign w_diff     = {w_in_s[DATA_WIDTH-1], w_in_s} - {w_pred_eff[DATA_WIDTH-1], w_pred_eff};
  assign w_val      = w_is_dc ? w_diff : {w_in_s[DATA_WIDTH-1], w_in_s};
  assign w_mag      = w_val[AW-1] ? (~w_val + AW'(1)) : w_val;
  assign w_amp_raw  = w_val[AW-1] ? (w_val - AW'(1)) : w_val;
  assign w_mask     = ~({AW{1'b1}} << w_size);
  assign w_amp      = w_amp_raw & w_mask;

  always_comb begin
    w_size = '0;
    for (int b = 0; b < AW; b++) begin
      if (w_mag[b]) w_size = 4'(b + 1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_RUN:   if (w_accept && !w_is_dc && w_nz && (r_zrl_pend != 2'd0)) w_state_next = S_FLUSH;
      S_FLUSH: if (w_out_fire && (r_zrl_pend == 2'd0)) w_state_next = S_RUN;
      default: w_state_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_RUN;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_index     <= '0;
      r_run       <= '0;
      r_zrl_pend  <= '0;
      r_pred      <= '0;
      r_out_valid <= 1'b0;
      r_out_dc    <= 1'b0;
      r_out_run   <= '0;
      r_out_size  <= '0;
      r_out_amp   <= '0;
      r_out_last  <= 1'b0;
      r_hold_run  <= '0;
      r_hold_size <= '0;
      r_hold_amp  <= '0;
      r_hold_last <= 1'b0;
    end else begin
      if (w_accept && w_is_dc) r_pred <= w_in_s;
      else if (dc_clear)       r_pred <= '0;

      if (r_state == S_RUN) begin
        if (w_out_fire) r_out_valid <= 1'b0;
        if (w_accept) begin
          r_index <= r_index + 6'd1;
          if (w_is_dc) begin
            r_out_valid <= 1'b1;
            r_out_dc    <= 1'b1;
            r_out_run   <= '0;
            r_out_size  <= w_size;
            r_out_amp   <= w_amp;
            r_out_last  <= 1'b0;
          end else if (w_nz) begin
            r_run       <= '0;
            r_out_valid <= 1'b1;
            r_out_dc    <= 1'b0;
            if (r_zrl_pend != 2'd0) begin
              // First ZRL goes straight out; the coefficient waits in the hold register.
              r_out_run   <= 4'd15;
              r_out_size  <= '0;
              r_out_amp   <= '0;
              r_out_last  <= 1'b0;
              r_zrl_pend  <= r_zrl_pend - 2'd1;
              r_hold_run  <= r_run;
              r_hold_size <= w_size;
              r_hold_amp  <= w_amp;
              r_hold_last <= w_is_last;
            end else begin
              r_out_run   <= r_run;
              r_out_size  <= w_size;
              r_out_amp   <= w_amp;
              r_out_last  <= w_is_last;
            end
          end else if (w_is_last) begin
            r_out_valid <= 1'b1;
            r_out_dc    <= 1'b0;
            r_out_run   <= '0;
            r_out_size  <= '0;
            r_out_amp   <= '0;
            r_out_last  <= 1'b1;
            r_run       <= '0;
            r_zrl_pend  <= '0;
          end else if (r_run == 4'd15) begin
            r_run <= '0;
            if (r_zrl_pend != 2'd3) r_zrl_pend <= r_zrl_pend + 2'd1;
          end else begin
            r_run <= r_run + 4'd1;
          end
        end
      end else if (w_out_fire) begin
        r_out_valid <= 1'b1;
        r_out_dc    <= 1'b0;
        if (r_zrl_pend != 2'd0) begin
          r_out_run  <= 4'd15;
          r_out_size <= '0;
          r_out_amp  <= '0;
          r_out_last <= 1'b0;
          r_zrl_pend <= r_zrl_pend - 2'd1;
        end else begin
          r_out_run  <= r_hold_run;
          r_out_size <= r_hold_size;
          r_out_amp  <= r_hold_amp;
          r_out_last <= r_hold_last;
        end
      end
    end
  end

`ifdef JPEG_RLE_STATS_EN
  logic [15:0] r_stat_blocks, r_stat_symbols;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_blocks  <= '0;
      r_stat_symbols <= '0;
    end else if (w_out_fire) begin
      r_stat_symbols <= r_stat_symbols + 16'd1;
      if (r_out_last) r_stat_blocks <= r_stat_blocks + 16'd1;
    end
  end

  assign stat_blocks  = r_stat_blocks;
  assign stat_symbols = r_stat_symbols;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_dc    = r_out_dc;
  assign bus.out_run   = r_out_run;
  assign bus.out_size  = r_out_size;
  assign bus.out_amp   = r_out_amp;
  assign bus.out_last  = r_out_last;
endmodule

// File: tb/tb_jpeg_rle_encoder.sv
// tb/tb_jpeg_rle_encoder.sv - self-checking bench for jpeg_rle_encoder with a symbol-list reference model
module tb_jpeg_rle_encoder;
  localparam int DW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dc_clear = 1'b0;
  always #5 clk = ~clk;

  jpeg_rle_if #(.DATA_WIDTH(DW)) bus();

`ifdef JPEG_RLE_STATS_EN
  logic [15:0] stat_blocks, stat_symbols;
`endif

  jpeg_rle_encoder #(.DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dc_clear     (dc_clear),
`ifdef JPEG_RLE_STATS_EN
    .stat_blocks  (stat_blocks),
    .stat_symbols (stat_symbols),
`endif
    .bus          (bus)
  );

  typedef struct {
    int dc;
    int run;
    int size;
    int amp;
    int last;
  } sym_t;

  sym_t exp_q[$];
  sym_t got_q[$];
  int   blk[64];
  int   m_pred;
  int   checks;
  int   errors;
  int   low_cnt;

  function automatic int size_of(int v);
    int m = (v < 0) ? -v : v;
    int s = 0;
    while (m != 0) begin
      s++;
      m = m >> 1;
    end
    return s;
  endfunction

  function automatic int amp_of(int v, int s);
    int a = (v < 0) ? v - 1 : v;
    return a & ((1 << s) - 1);
  endfunction

  function automatic bit sym_eq(sym_t a, sym_t b);
    return a.dc == b.dc && a.run == b.run && a.size == b.size && a.amp == b.amp && a.last == b.last;
  endfunction

  task automatic push_sym(input int dc, input int run, input int v, input int last);
    sym_t s;
    s.dc = dc; s.run = run; s.size = size_of(v); s.amp = amp_of(v, s.size); s.last = last;
    exp_q.push_back(s);
  endtask

  // Block -> symbol list straight from the JPEG rules: DC diff, zero runs split into 16s, EOB.
  task automatic build_expected(input bit dcclr);
    int zeros;
    exp_q.delete();
    push_sym(1, 0, blk[0] - (dcclr ? 0 : m_pred), 0);
    m_pred = blk[0];
    zeros = 0;
    for (int i = 1; i < 64; i++) begin
      if (blk[i] == 0) zeros++;
      else begin
        while (zeros >= 16) begin
          push_sym(0, 15, 0, 0);
          zeros -= 16;
        end
        push_sym(0, zeros, blk[i], (i == 63) ? 1 : 0);
        zeros = 0;
      end
    end
    if (blk[63] == 0) push_sym(0, 0, 0, 1);
  endtask

  function automatic sym_t cur_sym();
    sym_t s;
    s.dc = int'(bus.out_dc); s.run = int'(bus.out_run); s.size = int'(bus.out_size);
    s.amp = int'(bus.out_amp); s.last = int'(bus.out_last);
    return s;
  endfunction

  task automatic fill_random(input int density);
    for (int i = 0; i < 64; i++)
      blk[i] = ($urandom_range(0, 99) < density) ? $signed($urandom_range(0, 1023)) - 512 : 0;
  endtask

  task automatic clear_blk();
    for (int i = 0; i < 64; i++) blk[i] = 0;
  endtask

  // Drives one block; abort_cyc>0 stops early without comparing (used before a reset pulse).
  task automatic run_block(input string name, input bit rnd, input bit dcclr, input int abort_cyc);
    int   ptr = 0;
    int   cyc = 0;
    bit   going = 1'b1;
    bit   have_stall = 1'b0;
    sym_t stalled;
    sym_t s;
    int   n;
    if (abort_cyc == 0) build_expected(dcclr);
    got_q.delete();
    low_cnt = 0;
    while (going) begin
      @(negedge clk);
      bus.in_valid  = (ptr < 64) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      bus.in_data   = (ptr < 64) ? blk[ptr][DW-1:0] : '0;
      bus.out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      dc_clear      = dcclr && (ptr == 0);
      #1;
      if (have_stall) begin
        checks++;
        if (bus.out_valid !== 1'b1 || !sym_eq(cur_sym(), stalled)) begin
          errors++;
          $display("FAIL %s stall_hold: got valid=%0b run=%0d size=%0d amp=%0h, required valid=1 run=%0d size=%0d amp=%0h",
                   name, bus.out_valid, bus.out_run, bus.out_size, bus.out_amp, stalled.run, stalled.size, stalled.amp);
        end
      end
      s = cur_sym();
      if (bus.out_valid && bus.out_ready) got_q.push_back(s);
      have_stall = bus.out_valid && !bus.out_ready;
      stalled = s;
      if (bus.in_valid && !bus.in_ready && ptr < 64) low_cnt++;
      if (bus.in_valid && bus.in_ready) ptr++;
      cyc++;
      if (abort_cyc > 0) going = (cyc < abort_cyc);
      else going = !(ptr == 64 && got_q.size() >= exp_q.size()) && (cyc < 4000);
    end
    dc_clear = 1'b0;
    if (abort_cyc > 0) return;
    checks++;
    if (got_q.size() != exp_q.size() || ptr != 64) begin
      errors++;
      $display("FAIL %s symbol_count: got %0d symbols (%0d coefs taken), required %0d symbols (64 coefs)",
               name, got_q.size(), ptr, exp_q.size());
    end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (!sym_eq(got_q[i], exp_q[i])) begin
        errors++;
        $display("FAIL %s sym%0d: got dc=%0d run=%0d size=%0d amp=%0h last=%0d, required dc=%0d run=%0d size=%0d amp=%0h last=%0d",
                 name, i, got_q[i].dc, got_q[i].run, got_q[i].size, got_q[i].amp, got_q[i].last,
                 exp_q[i].dc, exp_q[i].run, exp_q[i].size, exp_q[i].amp, exp_q[i].last);
      end
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_dc !== 1'b0 || bus.out_run !== 4'd0 ||
        bus.out_size !== 4'd0 || bus.out_amp !== '0 || bus.out_last !== 1'b0) begin
      errors++;
      $display("FAIL %s: got valid=%0b ready=%0b dc=%0b run=%0d size=%0d amp=%0h last=%0b, required valid=0 ready=1 rest 0",
               name, bus.out_valid, bus.in_ready, bus.out_dc, bus.out_run, bus.out_size, bus.out_amp, bus.out_last);
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset_state");
    rst_n = 1'b1;
    m_pred = 0;
  endtask

  task automatic test_all_zero();
    clear_blk();
    run_block("all_zero", 1'b0, 1'b0, 0);
    checks++;
    if (got_q.size() != 2 || got_q[0].dc != 1 || got_q[0].size != 0 || got_q[1].last != 1 || got_q[1].size != 0) begin
      errors++;
      $display("FAIL all_zero_shape: got %0d symbols, required DC(size0) + EOB(last)", got_q.size());
    end
  endtask

  task automatic test_dc_diff();
    clear_blk(); blk[0] = 5;
    run_block("dc5", 1'b0, 1'b0, 0);
    clear_blk(); blk[0] = 3;
    run_block("dc3", 1'b0, 1'b0, 0);
    checks++;
    if (got_q.size() < 1 || got_q[0].size != 2 || got_q[0].amp != 1 || got_q[0].dc != 1) begin
      errors++;
      $display("FAIL dc_diff_minus2: got size=%0d amp=%0d, required size=2 amp=1",
               (got_q.size() > 0) ? got_q[0].size : -1, (got_q.size() > 0) ? got_q[0].amp : -1);
    end
  endtask

  task automatic test_ac_basic();
    clear_blk(); blk[0] = 3; blk[1] = -1; blk[3] = 3;
    run_block("ac_basic", 1'b0, 1'b0, 0);
  endtask

  task automatic test_zrl();
    clear_blk(); blk[41] = 1;
    run_block("zrl40", 1'b0, 1'b0, 0);
    checks++;
    if (low_cnt != 2) begin
      errors++;
      $display("FAIL zrl40_flush_stall: got %0d cycles in_ready low, required 2", low_cnt);
    end
  endtask

  task automatic test_last_nonzero();
    clear_blk(); blk[63] = 7;
    run_block("last_nz", 1'b0, 1'b0, 0);
  endtask

  task automatic test_extremes();
    clear_blk(); blk[0] = 511;
    run_block("dc_max", 1'b1, 1'b0, 0);
    clear_blk(); blk[0] = -512; blk[1] = -512; blk[17] = 511; blk[62] = -1;
    run_block("dc_min_diff", 1'b1, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int b = 0; b < 12; b++) begin
      fill_random((b % 3 == 0) ? 4 : 25);
      run_block("random", 1'b1, (b % 4 == 1), 0);
    end
  endtask

  task automatic test_reset_mid_block();
    fill_random(30);
    run_block("mid_abort", 1'b1, 1'b0, 37);
    #2 rst_n = 1'b0;
    #1 check_idle("async_reset_mid_block");
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_pred = 0;
  endtask

  task automatic test_back_to_back();
    fill_random(20);
    run_block("post_reset", 1'b1, 1'b0, 0);
    fill_random(10);
    run_block("b2b_dcclr", 1'b1, 1'b1, 0);
    fill_random(50);
    run_block("b2b_full", 1'b0, 1'b0, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_pred = 0;
    test_reset();
    test_all_zero();
    test_dc_diff();
    test_ac_basic();
    test_zrl();
    test_last_nonzero();
    test_extremes();
    test_random();
    test_reset_mid_block();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
